// File: rtl/opsum_writeback_if.sv
// Opsum valid/ready stream from the PE array plus the GLB word write port.
// The slave modport is the write-back stage; master is its environment.
interface opsum_writeback_if #(
    parameter int DATA_BITS = 32,
    parameter int ADDR_BITS = 16
);
    logic                 opsum_valid;
    logic                 opsum_ready;
    logic [DATA_BITS-1:0] opsum_data;
    logic                 glb_we;
    logic [ADDR_BITS-1:0] glb_addr;
    logic [DATA_BITS-1:0] glb_wdata;
    logic [3:0]           glb_bmask;

    modport master (
        output opsum_valid, opsum_data,
        input  opsum_ready,
        input  glb_we, glb_addr, glb_wdata, glb_bmask
    );

    modport slave (
        input  opsum_valid, opsum_data,
        output opsum_ready,
        output glb_we, glb_addr, glb_wdata, glb_bmask
    );
endinterface

// File: rtl/opsum_writeback.sv
// Opsum requant (round, shift, saturate to int8) and 4-byte packing into GLB words.
// Define OPSUM_RELU_EN to clamp negative results to zero before saturation.
module opsum_writeback #(
    parameter int DATA_BITS = 32,
    parameter int ADDR_BITS = 16,
    parameter int CNT_BITS  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_BITS-1:0] cfg_base_addr,
    input  logic [CNT_BITS-1:0]  cfg_num_outputs,
    input  logic [4:0]           cfg_shift,
    opsum_writeback_if.slave     bus,
    output logic                 busy,
    output logic                 done
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

    localparam logic signed [DATA_BITS:0] SAT_HI = (DATA_BITS+1)'(127);
    localparam logic signed [DATA_BITS:0] SAT_LO = (DATA_BITS+1)'(-128);

    state_t               r_state, w_state_next;
    logic [CNT_BITS-1:0]  r_remaining, w_remaining_next;
    logic                 r_ready, w_ready_next;
    logic [4:0]           r_shift;
    logic                 w_xfer, w_drained, w_flush_wr;

    logic                 r_in_valid;
    logic [DATA_BITS-1:0] r_in_data;
    logic                 r_q_valid;
    logic [7:0]           r_q_byte;
    logic [1:0]           r_lane;
    logic [23:0]          r_pack;
    logic [ADDR_BITS-1:0] r_addr;

    logic                 r_glb_we;
    logic [ADDR_BITS-1:0] r_glb_addr;
    logic [DATA_BITS-1:0] r_glb_wdata;
    logic [3:0]           r_glb_bmask;

    logic signed [DATA_BITS:0] w_round, w_sum, w_shifted;
    logic [7:0]                w_byte;

    assign w_xfer    = bus.opsum_valid && r_ready;
    assign w_drained = !r_in_valid && !r_q_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_remaining <= '0;
            r_ready     <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_remaining <= w_remaining_next;
            r_ready     <= w_ready_next;
        end
    end

    // FLUSH stays put for one extra cycle when it issues the partial write.
    always_comb begin
        w_state_next     = r_state;
        w_remaining_next = r_remaining;
        w_flush_wr       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_remaining_next = cfg_num_outputs;
                    w_state_next     = (cfg_num_outputs != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (w_xfer) begin
                    w_remaining_next = r_remaining - CNT_BITS'(1);
                    if (r_remaining == CNT_BITS'(1)) w_state_next = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (w_drained) begin
                    if (r_lane != 2'd0) w_flush_wr   = 1'b1;
                    else                w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
        w_ready_next = (w_state_next == S_RUN) && (w_remaining_next != '0);
    end

    always_comb begin
        w_round   = (r_shift == 5'd0) ? '0 : ((DATA_BITS+1)'(1) << (r_shift - 5'd1));
        w_sum     = $signed({r_in_data[DATA_BITS-1], r_in_data}) + w_round;
        w_shifted = w_sum >>> r_shift;
        w_byte    = w_shifted[7:0];
`ifdef OPSUM_RELU_EN
        if (w_shifted < 0)           w_byte = 8'h00;
        else if (w_shifted > SAT_HI) w_byte = 8'h7F;
`else
        if (w_shifted > SAT_HI)      w_byte = 8'h7F;
        else if (w_shifted < SAT_LO) w_byte = 8'h80;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift     <= '0;
            r_in_valid  <= 1'b0;
            r_in_data   <= '0;
            r_q_valid   <= 1'b0;
            r_q_byte    <= '0;
            r_lane      <= '0;
            r_pack      <= '0;
            r_addr      <= '0;
            r_glb_we    <= 1'b0;
            r_glb_addr  <= '0;
            r_glb_wdata <= '0;
            r_glb_bmask <= '0;
        end else begin
            r_in_valid <= w_xfer;
            if (w_xfer) r_in_data <= bus.opsum_data;
            r_q_valid <= r_in_valid;
            if (r_in_valid) r_q_byte <= w_byte;
            r_glb_we <= 1'b0;

            if (r_state == S_IDLE && start) begin
                r_shift <= cfg_shift;
                r_addr  <= cfg_base_addr;
                r_lane  <= '0;
                r_pack  <= '0;
            end

            if (r_q_valid) begin
                r_lane <= r_lane + 2'd1;
                if (r_lane == 2'd3) begin
                    r_glb_we    <= 1'b1;
                    r_glb_addr  <= r_addr;
                    r_glb_wdata <= DATA_BITS'({r_q_byte, r_pack});
                    r_glb_bmask <= 4'b1111;
                    r_addr      <= r_addr + ADDR_BITS'(1);
                    r_pack      <= '0;
                end else begin
                    r_pack[{r_lane, 3'b000} +: 8] <= r_q_byte;
                end
            end

            // Unfilled lanes of r_pack are already zero from the last clear.
            if (w_flush_wr) begin
                r_glb_we    <= 1'b1;
                r_glb_addr  <= r_addr;
                r_glb_wdata <= DATA_BITS'({8'h00, r_pack});
                r_glb_bmask <= (4'd1 << r_lane) - 4'd1;
                r_addr      <= r_addr + ADDR_BITS'(1);
                r_lane      <= '0;
                r_pack      <= '0;
            end
        end
    end

    assign bus.opsum_ready = r_ready;
    assign bus.glb_we      = r_glb_we;
    assign bus.glb_addr    = r_glb_addr;
    assign bus.glb_wdata   = r_glb_wdata;
    assign bus.glb_bmask   = r_glb_bmask;
    assign busy            = (r_state != S_IDLE);
    assign done            = (r_state == S_DONE);
endmodule
